// File: rtl/bp_update_sched.sv
// Write-port scheduler for the branch history / target table: an in-order
// update FIFO fed by the FU lanes, drained one entry per cycle, plus an init sweep FSM.
module bp_update_sched #(
    parameter int NUM_SUPER = 2,
    parameter int IDX_BITS  = 4,
    parameter int DEPTH     = 8,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_req,
    input  logic [NUM_SUPER-1:0]    fu_valid,
    input  logic [NUM_SUPER*64-1:0] fu_pc,
    input  logic [NUM_SUPER-1:0]    fu_taken,
    input  logic [NUM_SUPER*64-1:0] fu_target,
    input  logic [NUM_SUPER-1:0]    fu_mispredict,
    output logic                   fu_ready,
    input  logic                   tbl_ready,
    output logic                   tbl_wr_en,
    output logic [IDX_BITS-1:0]    tbl_wr_idx,
    output logic                   tbl_wr_init,
    output logic                   tbl_wr_taken,
    output logic                   tbl_wr_btb_en,
    output logic [63:0]            tbl_wr_target,
    output logic                   init_done,
    output logic [CNT_W-1:0]       count,
    output logic [1:0]             fsm_state
);

    localparam logic [1:0] INIT       = 2'd0;
    localparam logic [1:0] RUN        = 2'd1;
    localparam logic [1:0] CLEAR_WAIT = 2'd2;

    localparam logic [IDX_BITS-1:0] SWEEP_LAST = {IDX_BITS{1'b1}};

    // Handshake: an FU lane is accepted at a rising edge when fu_valid[i] and
    // fu_ready are both high (minus squashed lanes); a table write happens in
    // any cycle where tbl_wr_en is high, and tbl_wr_en never rises without tbl_ready.

    logic [1:0]          state;
    logic [IDX_BITS-1:0] sweep_idx;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;

    logic [IDX_BITS-1:0] q_idx    [DEPTH];
    logic                q_taken  [DEPTH];
    logic [63:0]         q_target [DEPTH];

    logic                lane_keep [NUM_SUPER];
    logic [PTR_W-1:0]    lane_slot [NUM_SUPER];
    logic [CNT_W-1:0]    enq_n;
    logic                squash;
    logic                deq;
    logic [CNT_W-1:0]    free_slots;
    logic                pc_unused;

    assign fsm_state  = state;
    assign free_slots = CNT_W'(DEPTH) - count;
    assign fu_ready   = reset && (state == RUN) && (free_slots >= CNT_W'(NUM_SUPER));
    assign deq        = ((state == RUN) || (state == CLEAR_WAIT)) && (count != '0) && tbl_ready;
    assign pc_unused  = ^fu_pc;

    // Accepted lanes are packed contiguously after the tail; a mispredicting
    // lane kills every younger lane in the same cycle.
    always_comb begin
        squash = 1'b0;
        enq_n  = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            lane_keep[i] = 1'b0;
            lane_slot[i] = '0;
            if (fu_ready && fu_valid[i] && !squash) begin
                lane_keep[i] = 1'b1;
                lane_slot[i] = tail + enq_n[PTR_W-1:0];
                enq_n        = enq_n + CNT_W'(1);
                if (fu_mispredict[i]) begin
                    squash = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (lane_keep[i]) begin
                q_idx[lane_slot[i]]    <= fu_pc[i*64+2 +: IDX_BITS];
                q_taken[lane_slot[i]]  <= fu_taken[i];
                q_target[lane_slot[i]] <= fu_target[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= INIT;
            sweep_idx <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            init_done <= 1'b0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + enq_n[PTR_W-1:0];
            count <= count + enq_n - CNT_W'(deq);
            case (state)
                INIT: begin
                    if (tbl_ready) begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (sweep_idx == SWEEP_LAST) begin
                            state     <= RUN;
                            init_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state <= CLEAR_WAIT;
                    end
                end
                CLEAR_WAIT: begin
                    // Pending updates land before the sweep wipes the table.
                    if (count == '0) begin
                        state     <= INIT;
                        sweep_idx <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    always_comb begin
        tbl_wr_en     = 1'b0;
        tbl_wr_idx    = '0;
        tbl_wr_init   = 1'b0;
        tbl_wr_taken  = 1'b0;
        tbl_wr_btb_en = 1'b0;
        tbl_wr_target = '0;
        if (reset) begin
            if (state == INIT) begin
                tbl_wr_en   = tbl_ready;
                tbl_wr_init = 1'b1;
                tbl_wr_idx  = sweep_idx;
            end else if (deq) begin
                tbl_wr_en     = 1'b1;
                tbl_wr_idx    = q_idx[head];
                tbl_wr_taken  = q_taken[head];
                tbl_wr_btb_en = q_taken[head];
                tbl_wr_target = q_target[head];
            end
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: every table write is checked against a
// queue of expected writes filled as stimulus is driven.
module tb_bp_update_sched;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CW   = 2'd2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         clear_req = 1'b0;
    logic [1:0]   fu_valid = '0;
    logic [127:0] fu_pc = '0;
    logic [1:0]   fu_taken = '0;
    logic [127:0] fu_target = '0;
    logic [1:0]   fu_mispredict = '0;
    logic         fu_ready;
    logic         tbl_ready = 1'b1;
    logic         tbl_wr_en;
    logic [3:0]   tbl_wr_idx;
    logic         tbl_wr_init;
    logic         tbl_wr_taken;
    logic         tbl_wr_btb_en;
    logic [63:0]  tbl_wr_target;
    logic         init_done;
    logic [3:0]   count;
    logic [1:0]   fsm_state;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [70:0] exp_q[$];

    bp_update_sched dut (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .fu_valid(fu_valid), .fu_pc(fu_pc), .fu_taken(fu_taken),
        .fu_target(fu_target), .fu_mispredict(fu_mispredict),
        .fu_ready(fu_ready), .tbl_ready(tbl_ready), .tbl_wr_en(tbl_wr_en),
        .tbl_wr_idx(tbl_wr_idx), .tbl_wr_init(tbl_wr_init),
        .tbl_wr_taken(tbl_wr_taken), .tbl_wr_btb_en(tbl_wr_btb_en),
        .tbl_wr_target(tbl_wr_target), .init_done(init_done),
        .count(count), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    function automatic logic [70:0] wr_rec(logic init, logic [3:0] idx, logic tk,
                                          logic btb, logic [63:0] tg);
        return {init, idx, tk, btb, tg};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 16; i++) exp_q.push_back(wr_rec(1'b1, i[3:0], 1'b0, 1'b0, 64'h0));
    endtask

    task automatic idle();
        fu_valid      = '0;
        fu_mispredict = '0;
    endtask

    // Drives both lanes; when accept is set, pushes the writes the lanes must
    // produce, applying the lane-0 mispredict squash to lane 1.
    task automatic drive(input logic [1:0] v, input logic [1:0] mp,
                         input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic [1:0] tk,
                         input logic [63:0] tg0, input logic [63:0] tg1,
                         input logic accept);
        fu_valid      = v;
        fu_mispredict = mp;
        fu_pc         = {pc1, pc0};
        fu_taken      = tk;
        fu_target     = {tg1, tg0};
        if (accept) begin
            if (v[0]) exp_q.push_back(wr_rec(1'b0, pc0[5:2], tk[0], tk[0], tg0));
            if (v[1] && !(v[0] && mp[0]))
                exp_q.push_back(wr_rec(1'b0, pc1[5:2], tk[1], tk[1], tg1));
        end
    endtask

    // Scoreboard: every observed write must match the head of the expected queue.
    always @(negedge clock) begin
        if (tbl_wr_en === 1'b1) begin
            tests_run++;
            assert (exp_q.size() != 0) else begin
                fail_cnt++;
                $error("FAIL wr_unexpected got=%0h exp=none",
                       {tbl_wr_init, tbl_wr_idx, tbl_wr_taken, tbl_wr_btb_en, tbl_wr_target});
            end
            if (exp_q.size() != 0) begin
                logic [70:0] e;
                e = exp_q.pop_front();
                assert ({tbl_wr_init, tbl_wr_idx, tbl_wr_taken, tbl_wr_btb_en, tbl_wr_target} === e)
                else begin
                    fail_cnt++;
                    $error("FAIL wr_data got=%0h exp=%0h",
                           {tbl_wr_init, tbl_wr_idx, tbl_wr_taken, tbl_wr_btb_en, tbl_wr_target}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rt;
        // reset state
        tick();
        tick();
        @(negedge clock);
        check("rst_count", count, 0);
        check("rst_init_done", init_done, 0);
        check("rst_fu_ready", fu_ready, 0);
        check("rst_wr_en", tbl_wr_en, 0);
        check("rst_state", fsm_state, S_INIT);

        // init sweep with tbl_ready held high
        tick();
        reset = 1'b1;
        push_init();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("sweep_en", tbl_wr_en, 1);
            check("sweep_idx", tbl_wr_idx, i);
            check("sweep_done_low", init_done, 0);
            check("sweep_fu_ready", fu_ready, 0);
        end
        @(negedge clock);
        check("init_done", init_done, 1);
        check("run_fu_ready", fu_ready, 1);
        check("run_idle_en", tbl_wr_en, 0);
        check("sweep_q_empty", exp_q.size(), 0);

        // init sweep with tbl_ready toggling
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        push_init();
        for (int c = 0; c < 32; c++) begin
            tbl_ready = (c % 2 == 0);
            @(negedge clock);
            check("stall_done", init_done, c == 31);
            check("stall_en", tbl_wr_en, c % 2 == 0);
            tick();
        end
        check("stall_q_empty", exp_q.size(), 0);

        // dual enqueue, no bypass
        tbl_ready = 1'b1;
        drive(2'b11, 2'b00, 64'h40, 64'h44, 2'b01, 64'h100, 64'h200, 1'b1);
        @(negedge clock);
        check("nobypass_en", tbl_wr_en, 0);
        tick();
        idle();
        @(negedge clock);
        check("dual_cnt2", count, 2);
        check("dual_btb0", tbl_wr_btb_en, 1);
        check("dual_tg0", tbl_wr_target, 64'h100);
        tick();
        @(negedge clock);
        check("dual_cnt1", count, 1);
        check("dual_idx1", tbl_wr_idx, 1);
        check("dual_btb1", tbl_wr_btb_en, 0);
        tick();
        @(negedge clock);
        check("dual_cnt0", count, 0);
        check("dual_idle", tbl_wr_en, 0);

        // squash of lane 1 by a lane-0 mispredict
        tick();
        tbl_ready = 1'b0;
        drive(2'b11, 2'b01, 64'h48, 64'h4c, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        tick();
        idle();
        @(negedge clock);
        check("squash_cnt", count, 1);
        tick();
        tbl_ready = 1'b1;
        tick();
        @(negedge clock);
        check("squash_drained", count, 0);

        // fill to backpressure, ignored lanes, drain with simultaneous enqueue
        tick();
        tbl_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rt = 2'($urandom_range(0, 3));
            drive(2'b11, 2'b00, 64'h80 + 64'(8 * k), 64'h84 + 64'(8 * k), rt,
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            tick();
        end
        idle();
        @(negedge clock);
        check("full_cnt6", count, 6);
        check("full_ready6", fu_ready, 1);
        tick();
        drive(2'b01, 2'b00, 64'hb0, 64'hb4, 2'b01, 64'hdead, 64'h0, 1'b1);
        tick();
        drive(2'b11, 2'b00, 64'hb8, 64'hbc, 2'b11, 64'h1, 64'h2, 1'b0);
        @(negedge clock);
        check("full_cnt7", count, 7);
        check("full_ready7", fu_ready, 0);
        tick();
        idle();
        tbl_ready = 1'b1;
        @(negedge clock);
        check("ignored_cnt7", count, 7);
        check("drain_ready7", fu_ready, 0);
        tick();
        drive(2'b11, 2'b00, 64'hc8, 64'hcc, 2'b10, 64'h55, 64'h66, 1'b1);
        @(negedge clock);
        check("drain_cnt6", count, 6);
        check("drain_ready6", fu_ready, 1);
        tick();
        idle();
        @(negedge clock);
        check("simul_cnt7", count, 7);
        for (int n = 0; n < 20 && count != 0; n++) tick();
        check("drain_cnt0", count, 0);
        check("drain_q_empty", exp_q.size(), 0);

        // clear with pending updates, then reset mid-sweep
        tbl_ready = 1'b0;
        drive(2'b11, 2'b00, 64'hd0, 64'hd4, 2'b11, 64'h1000, 64'h2000, 1'b1);
        tick();
        drive(2'b01, 2'b00, 64'hd8, 64'h0, 2'b00, 64'h3000, 64'h0, 1'b1);
        tick();
        idle();
        @(negedge clock);
        check("clr_cnt3", count, 3);
        tick();
        clear_req = 1'b1;
        push_init();
        tick();
        clear_req = 1'b0;
        @(negedge clock);
        check("clr_state", fsm_state, S_CW);
        check("clr_fu_ready", fu_ready, 0);
        tick();
        tbl_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (tbl_wr_en && tbl_wr_init) break;
            tick();
        end
        check("clr_sweep_init", tbl_wr_init, 1);
        check("clr_sweep_idx0", tbl_wr_idx, 0);
        check("clr_done_low", init_done, 0);
        check("clr_sweep_ready", fu_ready, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            @(negedge clock);
        end
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        clear_req = 1'b1;
        push_init();
        @(negedge clock);
        check("restart_idx0", tbl_wr_idx, 0);
        check("restart_init", tbl_wr_init, 1);
        tick();
        clear_req = 1'b0;
        for (int n = 0; n < 30 && init_done != 1'b1; n++) tick();
        @(negedge clock);
        check("restart_done", init_done, 1);
        check("restart_state", fsm_state, S_RUN);
        check("restart_ready", fu_ready, 1);
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
